// File: rtl/lcd_read_port.sv
// HD44780 read-cycle engine on the 6502 bus: a CPU write to CTRL runs one LCD
// read (RW/RS/EN sequencing) and latches LCD_DATA into DATA for the CPU.
module lcd_read_port #(
    parameter logic [15:0] BASE_ADDR = 16'hFFF8,
    parameter int          SETUP_CYC = 2,
    parameter int          EN_CYC    = 4,
    parameter int          HOLD_CYC  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  data_in,
    input  logic        read_write,
    output logic [7:0]  data_out,
    output logic        selected,
    input  logic [7:0]  lcd_data_in,
    output logic        lcd_en,
    output logic        lcd_rw,
    output logic        lcd_rs,
    output logic        lcd_data_oe,
    output logic        active
);

    typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_t;

    localparam logic [15:0] DATA_ADDR  = BASE_ADDR + 16'd1;
    localparam logic [7:0]  SETUP_LOAD = 8'(SETUP_CYC - 1);
    localparam logic [7:0]  EN_LOAD    = 8'(EN_CYC - 1);
    localparam logic [7:0]  HOLD_LOAD  = 8'(HOLD_CYC - 1);

    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    logic       start_pend;
    logic       capture, finish;
    logic [7:0] data_reg;
    logic       valid;

    logic ctrl_wr, start_acc, data_rd;
    logic unused_bits;

    assign selected  = (address == BASE_ADDR) || (address == DATA_ADDR);
    assign ctrl_wr   = read_write && (address == BASE_ADDR);
    assign data_rd   = !read_write && (address == DATA_ADDR);
    // A start arriving while a cycle is pending or running is dropped.
    assign start_acc = ctrl_wr && data_in[1] && (state == IDLE) && !start_pend;
    assign active    = (state != IDLE);
    assign unused_bits = &{1'b0, data_in[7:2]};

    // NOTE: every sequential block uses non-blocking (<=) so all flops update
    // together on the edge; blocking assignments here would create ordering races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start_pend) begin
                    state_next = SETUP;
                    cnt_next   = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    state_next = ENABLE;
                    cnt_next   = EN_LOAD;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            ENABLE: begin
                if (cnt == 8'd0) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LOAD;
                    capture    = 1'b1;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            HOLD: begin
                if (cnt == 8'd0) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // LCD pins are decoded from the next state so they are registered and
    // change on the same edge as the state itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_pend  <= 1'b0;
            lcd_en      <= 1'b0;
            lcd_rw      <= 1'b0;
            lcd_rs      <= 1'b0;
            lcd_data_oe <= 1'b1;
            data_reg    <= 8'h00;
            valid       <= 1'b0;
        end else begin
            start_pend  <= start_acc;
            lcd_en      <= (state_next == ENABLE);
            lcd_rw      <= (state_next != IDLE);
            lcd_data_oe <= (state_next == IDLE);
            if (start_acc)
                lcd_rs <= data_in[0];
            if (capture)
                data_reg <= lcd_data_in;
            if (finish)
                valid <= 1'b1;
            else if (start_acc || data_rd)
                valid <= 1'b0;
        end
    end

    always_comb begin
        data_out = 8'h00;
        if (address == BASE_ADDR)
            data_out = {6'b0, valid, active};
        else if (address == DATA_ADDR)
            data_out = data_reg;
    end

endmodule

// File: tb/tb_lcd_read_port.sv
// Directed self-checking bench for lcd_read_port: timing of one LCD read,
// busy-flag read, ignored restart, capture point, decode and async reset.
module tb_lcd_read_port;

    localparam logic [15:0] CTRL_A = 16'hFFF8;
    localparam logic [15:0] DATA_A = 16'hFFF9;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic [7:0]  data_in;
    logic        read_write;
    logic [7:0]  data_out;
    logic        selected;
    logic [7:0]  lcd_data_in;
    logic        lcd_en, lcd_rw, lcd_rs, lcd_data_oe, active;

    int   n_cmp = 0;
    int   n_err = 0;
    int   en_hi, en_rise;
    logic en_prev;
    logic [7:0] rd;

    lcd_read_port dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .data_in     (data_in),
        .read_write  (read_write),
        .data_out    (data_out),
        .selected    (selected),
        .lcd_data_in (lcd_data_in),
        .lcd_en      (lcd_en),
        .lcd_rw      (lcd_rw),
        .lcd_rs      (lcd_rs),
        .lcd_data_oe (lcd_data_oe),
        .active      (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        address    = 16'h0000;
        data_in    = 8'h00;
        read_write = 1'b0;
    endtask

    // Returns 1 time unit after the edge that samples the write.
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        address    = a;
        data_in    = d;
        read_write = 1'b1;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        address    = a;
        read_write = 1'b0;
        #1;
        d = data_out;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    initial begin
        bus_idle();
        lcd_data_in = 8'h00;
        reset       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_en",     {7'b0, lcd_en},      8'h00);
        check("rst_rw",     {7'b0, lcd_rw},      8'h00);
        check("rst_rs",     {7'b0, lcd_rs},      8'h00);
        check("rst_oe",     {7'b0, lcd_data_oe}, 8'h01);
        check("rst_active", {7'b0, active},      8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Data read with RS=1: en high for cycles 3..6, valid at cycle 9.
        lcd_data_in = 8'hA5;
        cpu_write(CTRL_A, 8'h03);
        check("t2_pend_active", {7'b0, active}, 8'h00);
        check("t2_rs",          {7'b0, lcd_rs}, 8'h01);
        en_hi = 0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            if (lcd_en) en_hi++;
            check($sformatf("t2_en_c%0d", k), {7'b0, lcd_en}, {7'b0, (k >= 3 && k <= 6)});
            if (k == 1) begin
                check("t2_rw",     {7'b0, lcd_rw},      8'h01);
                check("t2_oe",     {7'b0, lcd_data_oe}, 8'h00);
                check("t2_active", {7'b0, active},      8'h01);
            end
            if (k == 8) check("t2_valid_c8", {7'b0, dut.valid}, 8'h00);
        end
        check("t2_en_len",  en_hi[7:0],          8'd4);
        check("t2_valid",   {7'b0, dut.valid},   8'h01);
        check("t2_idle_rw", {7'b0, lcd_rw},      8'h00);
        check("t2_idle_oe", {7'b0, lcd_data_oe}, 8'h01);

        // CTRL/DATA reads; a DATA read clears valid after returning it.
        cpu_read(CTRL_A, rd);  check("t2_ctrl",   rd, 8'h02);
        cpu_read(DATA_A, rd);  check("t5_data1",  rd, 8'hA5);
        cpu_read(DATA_A, rd);  check("t5_data2",  rd, 8'hA5);
        cpu_read(CTRL_A, rd);  check("t5_ctrl0",  rd, 8'h00);

        // Busy-flag read with RS=0.
        lcd_data_in = 8'h80;
        cpu_write(CTRL_A, 8'h02);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) check("t3_rs", {7'b0, lcd_rs}, 8'h00);
        end
        cpu_read(CTRL_A, rd);  check("t3_ctrl", rd, 8'h02);
        cpu_read(DATA_A, rd);  check("t3_data", rd, 8'h80);

        // Restart during the third ENABLE cycle must be ignored.
        lcd_data_in = 8'h3C;
        cpu_write(CTRL_A, 8'h03);
        en_hi   = 0;
        en_rise = 0;
        en_prev = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 6) begin
                address    = CTRL_A;
                data_in    = 8'h02;
                read_write = 1'b1;
            end else begin
                bus_idle();
            end
            @(posedge clk);
            #1;
            if (lcd_en) en_hi++;
            if (lcd_en && !en_prev) en_rise++;
            en_prev = lcd_en;
            if (k == 9) check("t4_valid_c9", {7'b0, dut.valid}, 8'h01);
        end
        bus_idle();
        check("t4_en_len",    en_hi[7:0],      8'd4);
        check("t4_en_pulses", en_rise[7:0],    8'd1);
        check("t4_active",    {7'b0, active},  8'h00);
        check("t4_rs",        {7'b0, lcd_rs},  8'h01);
        cpu_read(DATA_A, rd);  check("t4_data", rd, 8'h3C);

        // lcd_data_in changes every cycle; only the last ENABLE cycle's value lands.
        cpu_write(CTRL_A, 8'h02);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            lcd_data_in = 8'h10 + 8'(k);
            @(posedge clk);
            #1;
        end
        cpu_write(DATA_A, 8'h55);
        cpu_read(CTRL_A, rd);  check("t6_ctrl_after_dwr", rd, 8'h02);
        @(negedge clk);
        address    = 16'hFFFA;
        data_in    = 8'h03;
        read_write = 1'b1;
        #1;
        check("t6_sel_plus2",  {7'b0, selected}, 8'h00);
        check("t6_dout_plus2", data_out,         8'h00);
        @(posedge clk);
        #1;
        bus_idle();
        repeat (2) @(posedge clk);
        #1;
        check("t6_no_start", {7'b0, active}, 8'h00);
        cpu_read(DATA_A, rd);  check("t6_capture", rd, 8'h17);

        // Async reset in the middle of ENABLE.
        cpu_write(CTRL_A, 8'h03);
        repeat (4) @(posedge clk);
        #1;
        check("t1_en_before", {7'b0, lcd_en}, 8'h01);
        #3;
        address = DATA_A;
        reset   = 1'b1;
        #1;
        check("t1_en",     {7'b0, lcd_en},    8'h00);
        check("t1_active", {7'b0, active},    8'h00);
        check("t1_valid",  {7'b0, dut.valid}, 8'h00);
        check("t1_data",   data_out,          8'h00);
        check("t1_rs",     {7'b0, lcd_rs},    8'h00);
        @(negedge clk);
        reset = 1'b0;
        bus_idle();
        repeat (2) @(posedge clk);
        #1;
        check("t1_stays_idle", {7'b0, active}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
